// File: rtl/req_sync_arbiter.sv
// Round-robin arbiter for a single-owner resource shared by N requesters whose
// request lines are asynchronous to clk; includes a hold-time watchdog with lockout.
module req_sync_arbiter #(
    parameter int unsigned N        = 4,
    parameter logic [15:0] MAX_HOLD = 16'd1000,
    localparam int unsigned IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   s1;
    logic [N-1:0]   req_s;
    logic [N-1:0]   lock;
    logic [N-1:0]   elig;
    logic [IDW-1:0] ptr;
    logic [15:0]    hold_cnt;
    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] idx;

    assign elig = req_s & ~lock;

    // Scan downward so the eligible requester closest to ptr is the one left standing.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int off = int'(N) - 1; off >= 0; off--) begin
            idx = IDW'((int'(ptr) + off) % int'(N));
            if (elig[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            s1       <= '0;
            req_s    <= '0;
            lock     <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            s1      <= req;
            req_s   <= s1;
            timeout <= 1'b0;
            // A lock persists only while the synchronized request stays high.
            lock    <= lock & req_s;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant    <= N'(1) << pick_idx;
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req_s[grant_id]) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= RELEASE;
                    end else if ((MAX_HOLD != 16'd0) && (hold_cnt == MAX_HOLD - 16'd1)) begin
                        grant          <= '0;
                        busy           <= 1'b0;
                        timeout        <= 1'b1;
                        lock[grant_id] <= 1'b1;
                        state          <= RELEASE;
                    end else if (hold_cnt != 16'hFFFF) begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                RELEASE: begin
                    ptr   <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_sync_arbiter.sv
// Directed bench for req_sync_arbiter: three instances (watchdog off, 5 and 1)
// share clock, reset and request stimulus; each test checks the relevant instance.
module tb_req_sync_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] g0, g5, g1;
    logic [1:0] id0, id5, id1;
    logic       b0, b5, b1;
    logic       t0, t5, t1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    req_sync_arbiter #(.N(4), .MAX_HOLD(16'd0)) dut0 (
        .clk(clk), .reset(reset), .req(req),
        .grant(g0), .grant_id(id0), .busy(b0), .timeout(t0)
    );
    req_sync_arbiter #(.N(4), .MAX_HOLD(16'd5)) dut5 (
        .clk(clk), .reset(reset), .req(req),
        .grant(g5), .grant_id(id5), .busy(b5), .timeout(t5)
    );
    req_sync_arbiter #(.N(4), .MAX_HOLD(16'd1)) dut1 (
        .clk(clk), .reset(reset), .req(req),
        .grant(g1), .grant_id(id1), .busy(b1), .timeout(t1)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_g0(input bit want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((|g0) == want) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic wait_g5(input bit want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((|g5) == want) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (g0 !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b expected 0000", g0); end
        checks++; if (id0 !== 2'd0) begin fails++; $display("FAIL reset_id: got %0d expected 0", id0); end
        checks++; if (b0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", b0); end
        checks++; if (t0 !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", t0); end
        checks++; if ({g5, t5, g1, t1} !== 10'd0) begin fails++; $display("FAIL reset_others: got %b expected 0", {g5, t5, g1, t1}); end
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0100;
        step(2);
        checks++; if (g0 !== 4'b0000) begin fails++; $display("FAIL single_latency: got %b expected 0000", g0); end
        step(1);
        checks++; if (g0 !== 4'b0100) begin fails++; $display("FAIL single_grant: got %b expected 0100", g0); end
        checks++; if (id0 !== 2'd2) begin fails++; $display("FAIL single_id: got %0d expected 2", id0); end
        checks++; if (b0 !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", b0); end
        step(7);
        req = 4'b0000;
        step(2);
        checks++; if (g0 !== 4'b0100) begin fails++; $display("FAIL single_hold: got %b expected 0100", g0); end
        step(1);
        checks++; if (g0 !== 4'b0000) begin fails++; $display("FAIL single_release: got %b expected 0000", g0); end
        checks++; if ({b0, t0} !== 2'b00) begin fails++; $display("FAIL single_busy_to: got %b expected 00", {b0, t0}); end
        checks++; if (id0 !== 2'd2) begin fails++; $display("FAIL single_id_hold: got %0d expected 2", id0); end
    endtask

    task automatic test_rotation();
        bit         ok;
        int         zeros;
        logic [3:0] expg;
        apply_reset();
        req = 4'b1111;
        wait_g0(1'b1, ok);
        for (int r = 0; r < 6; r++) begin
            expg = 4'(1) << (r % 4);
            checks++; if (!ok) begin fails++; $display("FAIL rot_wait%0d: got no grant expected grant", r); end
            checks++; if (g0 !== expg) begin fails++; $display("FAIL rot_grant%0d: got %b expected %b", r, g0, expg); end
            checks++; if (id0 !== 2'(r % 4)) begin fails++; $display("FAIL rot_id%0d: got %0d expected %0d", r, id0, r % 4); end
            if (r < 5) begin
                req[r % 4] = 1'b0;
                step(1);
                req[r % 4] = 1'b1;
                step(1);
                zeros = 0;
                ok = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    step(1);
                    if (g0 != 4'b0000) begin
                        ok = 1'b1;
                        break;
                    end
                    zeros++;
                end
                checks++; if (zeros != 2) begin fails++; $display("FAIL rot_gap%0d: got %0d expected 2", r, zeros); end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        req = 4'b1000;
        wait_g0(1'b1, ok);
        checks++; if (!ok || id0 !== 2'd3) begin fails++; $display("FAIL wrap_first: got %0d expected 3", id0); end
        req = 4'b0000;
        wait_g0(1'b0, ok);
        req = 4'b0101;
        wait_g0(1'b1, ok);
        checks++; if (!ok || g0 !== 4'b0001) begin fails++; $display("FAIL wrap_zero: got %b expected 0001", g0); end
        req = 4'b0100;
        wait_g0(1'b0, ok);
        wait_g0(1'b1, ok);
        checks++; if (!ok || g0 !== 4'b0100 || id0 !== 2'd2) begin fails++; $display("FAIL wrap_two: got %b/%0d expected 0100/2", g0, id0); end
        req = 4'b0000;
    endtask

    task automatic test_watchdog();
        bit ok;
        int hi;
        int tc;
        int nz;
        apply_reset();
        req = 4'b0010;
        wait_g5(1'b1, ok);
        checks++; if (!ok || g5 !== 4'b0010 || id5 !== 2'd1) begin fails++; $display("FAIL wd_grant: got %b/%0d expected 0010/1", g5, id5); end
        req = 4'b0011;
        hi = 1;
        tc = 0;
        for (int i = 0; i < 20 && g5 == 4'b0010; i++) begin
            step(1);
            if (t5) tc++;
            if (g5 == 4'b0010) hi++;
        end
        checks++; if (hi != 5) begin fails++; $display("FAIL wd_len: got %0d expected 5", hi); end
        checks++; if ({g5, b5, t5} !== 6'b000001) begin fails++; $display("FAIL wd_pulse: got %b expected 000001", {g5, b5, t5}); end
        step(1);
        checks++; if (t5 !== 1'b0) begin fails++; $display("FAIL wd_pulse_end: got %b expected 0", t5); end
        step(1);
        checks++; if (g5 !== 4'b0001) begin fails++; $display("FAIL wd_next: got %b expected 0001", g5); end
        req = 4'b0010;
        wait_g5(1'b0, ok);
        nz = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (g5 != 4'b0000) nz++;
            if (t5) tc++;
        end
        checks++; if (nz != 0) begin fails++; $display("FAIL wd_lockout: got %0d grant cycles expected 0", nz); end
        checks++; if (tc != 1) begin fails++; $display("FAIL wd_once: got %0d pulses expected 1", tc); end
        req = 4'b0000;
        step(1);
        req = 4'b0010;
        wait_g5(1'b1, ok);
        checks++; if (!ok || g5 !== 4'b0010) begin fails++; $display("FAIL wd_regrant: got %b expected 0010", g5); end
        req = 4'b0000;
    endtask

    task automatic test_simultaneous();
        bit ok;
        apply_reset();
        req = 4'b0010;
        wait_g5(1'b1, ok);
        checks++; if (!ok) begin fails++; $display("FAIL simul_wait: got no grant expected grant"); end
        step(2);
        req = 4'b0000;
        step(2);
        checks++; if (g5 !== 4'b0010) begin fails++; $display("FAIL simul_hold: got %b expected 0010", g5); end
        step(1);
        checks++; if ({g5, t5} !== 5'b00000) begin fails++; $display("FAIL simul_release: got %b expected 00000", {g5, t5}); end
        checks++; if (dut5.lock !== 4'b0000) begin fails++; $display("FAIL simul_lock: got %b expected 0000", dut5.lock); end
        step(1);
        checks++; if (t5 !== 1'b0) begin fails++; $display("FAIL simul_late_to: got %b expected 0", t5); end
    endtask

    task automatic test_max_hold_one();
        apply_reset();
        req = 4'b0001;
        step(3);
        checks++; if (g1 !== 4'b0001 || b1 !== 1'b1 || id1 !== 2'd0) begin fails++; $display("FAIL mh1_grant: got %b/%b/%0d expected 0001/1/0", g1, b1, id1); end
        step(1);
        checks++; if ({g1, t1} !== 5'b00001) begin fails++; $display("FAIL mh1_timeout: got %b expected 00001", {g1, t1}); end
        step(1);
        checks++; if (t1 !== 1'b0) begin fails++; $display("FAIL mh1_pulse_end: got %b expected 0", t1); end
        step(3);
        checks++; if (g1 !== 4'b0000) begin fails++; $display("FAIL mh1_locked: got %b expected 0000", g1); end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        req = 4'b0010;
        wait_g0(1'b1, ok);
        checks++; if (!ok || g0 !== 4'b0010) begin fails++; $display("FAIL rmid_grant: got %b expected 0010", g0); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({g0, b0, t0} !== 6'b000000) begin fails++; $display("FAIL rmid_async: got %b expected 000000", {g0, b0, t0}); end
        @(negedge clk);
        reset = 1'b0;
        step(1);
        checks++; if (g0 !== 4'b0000) begin fails++; $display("FAIL rmid_edge1: got %b expected 0000", g0); end
        step(1);
        checks++; if (g0 !== 4'b0000) begin fails++; $display("FAIL rmid_edge2: got %b expected 0000", g0); end
        step(1);
        checks++; if (g0 !== 4'b0010) begin fails++; $display("FAIL rmid_edge3: got %b expected 0010", g0); end
        req = 4'b0000;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_watchdog();
        test_simultaneous();
        test_max_hold_one();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
